instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage of the RISC-V core. Owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. The instruction memory reads combinationally from the PC, so the next clock edge captures the word. The block handles hazard stalls, branch/jump redirects with a single-bubble flush, misaligned-target detection, and halt on EBREAK.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, word placed in IF/ID when the register is empty or flushed (ADDI x0,x0,0).
- HALT_INSN, 32'h0010_0073, fetched word that halts the fetch unit (EBREAK).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; returns every register to its reset value immediately.
- stall_i  in  1  hazard unit request to hold the PC and IF/ID.
- redirect_i  in  1  taken branch/jump from EX; single-cycle pulse.
- redirect_target_i  in  32  new PC, sampled when redirect_i=1.
- address_bus_IR  out  32  byte address to the instruction memory; equals the PC register, combinational.
- inst_mem_bus_IR  in  32  instruction word from memory (byte[addr] in [31:24]).
- if_id_pc_o  out  32  PC of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  sticky; a redirect target had a nonzero [1:0].
- halted_o  out  1  fetch is frozen (HALT_INSN fetched or misaligned redirect).
- fetch_count_o  out  32  number of valid instructions captured; saturating.

## Operation
- Reset values: pc=RESET_PC, if_id_pc_o=0, if_id_instr_o=NOP_INSN, if_id_valid_o=0, misalign_o=0, halted_o=0, fetch_count_o=0, state=BOOT.
- FSM states: BOOT, RUN, HALTED.
- BOOT: lasts one cycle after reset release and gives the memory image time to settle. There is no capture and no PC increment. Next state is RUN, whatever the value of stall_i.
- BOOT with redirect: a redirect during BOOT is accepted as in RUN.
- RUN, priority order per edge: redirect, then stall, then normal fetch.
  - Redirect, aligned target: pc<=target; IF/ID<={pc,NOP_INSN,valid=0} (flush). The redirect overrides stall_i.
  - Redirect, target[1:0]!=0: misalign_o<=1, halted_o<=1; pc unchanged; IF/ID flushed; state becomes HALTED.
  - Stall: pc and all IF/ID fields hold. A held invalid entry stays invalid.
  - Normal fetch: IF/ID<={pc,inst_mem_bus_IR,1}; pc<=pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0); fetch_count_o+1, saturating at 0xFFFF_FFFF.
  - Normal fetch of HALT_INSN: the word is captured as valid so downstream executes it; pc is not incremented; state becomes HALTED; halted_o<=1.
- HALTED:
  - On the first edge, IF/ID becomes {held pc, NOP_INSN, 0}. It then stays there.
  - pc is frozen. stall_i and redirect_i are ignored. fetch_count_o is frozen.
  - Only reset exits this state.
- Reset asserted mid-operation: all state returns to the reset values asynchronously. In-flight IF/ID contents are discarded.

## Timing
- address_bus_IR follows the PC register with zero cycles of logic (direct register output).
- Fetch latency: the word at PC p appears in IF/ID one edge after p is on address_bus_IR.
- First valid IF/ID appears at the 2nd rising edge after reset deasserts (edge 1: BOOT→RUN; edge 2: capture at RESET_PC).
- Redirect penalty: one bubble. The target is on the address bus after edge n, and its instruction is valid in IF/ID after edge n+1.
- Steady RUN with no stall: one instruction per cycle.
- halted_o and misalign_o assert on the same edge that enters HALTED.

## Test plan
- Reset release with the standard memory image, no stall:
  - Edge 2: if_id_pc_o=0, if_id_instr_o=0x003100B3, valid=1.
  - Edge 3: if_id_pc_o=4, if_id_instr_o=0x00308233.
  - Edge 4: if_id_pc_o=8, if_id_instr_o=0x01E00203; fetch_count_o=3.
- Assert stall_i for 2 cycles while pc=8:
  - address_bus_IR stays 8; IF/ID holds {4,0x00308233,1}.
  - First edge after release captures {8,0x01E00203,1}.
- redirect_i=1, target=0x14, with stall_i=1 in the same cycle:
  - Next edge: pc=0x14, IF/ID={*,0x00000013,0}.
  - Following edge: IF/ID={0x14,0x0000027F,1}.
- redirect_i=1, target=0x16:
  - misalign_o=1, halted_o=1, valid=0, pc unchanged.
  - A later redirect to 0x0 is ignored.
  - Reset clears misalign_o and halted_o.
- Bench memory model returns 0x00100073 at pc=0x20:
  - That edge captures {0x20,0x00100073,1}.
  - Next edge: valid=0, halted_o=1; pc stays 0x20; fetch_count_o frozen.
- Assert reset asynchronously between edges while pc=0x10:
  - Without any clock edge, pc=0, valid=0, if_id_instr_o=0x13, fetch_count_o=0.
  - After release, the BOOT sequence repeats exactly.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RISC-V core: owns the PC, drives the instruction memory
// address and fills the IF/ID register, with stall, redirect and halt handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSN = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] address_bus_IR,
  input  logic [31:0] inst_mem_bus_IR,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misalign_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] if_id_pc_r;
  logic [31:0] if_id_instr_r;
  logic        if_id_valid_r;
  logic        misalign_r;
  logic        halted_r;
  logic [31:0] fetch_count_r;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    pc_plus4 = pc + 32'd4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    sat_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  function automatic logic is_aligned(input logic [31:0] addr);
    is_aligned = (addr[1:0] == 2'b00);
  endfunction

  // PC, IF/ID register, sticky status and fetch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= NOP_INSN;
      if_id_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        BOOT, RUN: begin
          if (redirect_i) begin
            // A redirect always flushes, and wins over a stall.
            if_id_pc_r    <= pc_r;
            if_id_instr_r <= NOP_INSN;
            if_id_valid_r <= 1'b0;
            if (is_aligned(redirect_target_i)) begin
              pc_r    <= redirect_target_i;
              state_r <= RUN;
            end else begin
              misalign_r <= 1'b1;
              halted_r   <= 1'b1;
              state_r    <= HALTED;
            end
          end else if (state_r == BOOT) begin
            state_r <= RUN;
          end else if (stall_i) begin
            pc_r          <= pc_r;
            if_id_pc_r    <= if_id_pc_r;
            if_id_instr_r <= if_id_instr_r;
            if_id_valid_r <= if_id_valid_r;
          end else begin
            if_id_pc_r    <= pc_r;
            if_id_instr_r <= inst_mem_bus_IR;
            if_id_valid_r <= 1'b1;
            fetch_count_r <= sat_inc(fetch_count_r);
            // EBREAK is passed downstream but the PC stops on it.
            if (inst_mem_bus_IR == HALT_INSN) begin
              halted_r <= 1'b1;
              state_r  <= HALTED;
            end else begin
              pc_r <= pc_plus4(pc_r);
            end
          end
        end
        HALTED: begin
          if_id_pc_r    <= pc_r;
          if_id_instr_r <= NOP_INSN;
          if_id_valid_r <= 1'b0;
        end
        default: begin
          if_id_pc_r    <= pc_r;
          if_id_instr_r <= NOP_INSN;
          if_id_valid_r <= 1'b0;
          halted_r      <= 1'b1;
          state_r       <= HALTED;
        end
      endcase
    end
  end

  assign address_bus_IR = pc_r;
  assign if_id_pc_o     = if_id_pc_r;
  assign if_id_instr_o  = if_id_instr_r;
  assign if_id_valid_o  = if_id_valid_r;
  assign misalign_o     = misalign_r;
  assign halted_o       = halted_r;
  assign fetch_count_o  = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational
// instruction memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] address_bus_IR;
  logic [31:0] inst_mem_bus_IR;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        misalign_o;
  logic        halted_o;
  logic [31:0] fetch_count_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .address_bus_IR    (address_bus_IR),
    .inst_mem_bus_IR   (inst_mem_bus_IR),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_valid_o     (if_id_valid_o),
    .misalign_o        (misalign_o),
    .halted_o          (halted_o),
    .fetch_count_o     (fetch_count_o)
  );

  assign inst_mem_bus_IR = mem[address_bus_IR[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset             = 1'b1;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0000_0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset             = 1'b1;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0000_0000;
    #1;
    total++; if (address_bus_IR !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", address_bus_IR, 32'h0); end
    total++; if (if_id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_if_id_pc: got %h want %h", if_id_pc_o, 32'h0); end
    total++; if (if_id_instr_o !== 32'h13) begin bad++; $display("FAIL reset_instr: got %h want %h", if_id_instr_o, 32'h13); end
    total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_id_valid_o); end
    total++; if (misalign_o !== 1'b0 || halted_o !== 1'b0) begin bad++; $display("FAIL reset_flags: got mis=%b halt=%b want 0 0", misalign_o, halted_o); end
    total++; if (fetch_count_o !== 32'h0) begin bad++; $display("FAIL reset_count: got %0d want 0", fetch_count_o); end
  endtask

  task automatic test_boot;
    do_reset();
    tick();
    total++; if (if_id_valid_o !== 1'b0 || address_bus_IR !== 32'h0) begin bad++; $display("FAIL boot_edge1: got valid=%b pc=%h want 0 00000000", if_id_valid_o, address_bus_IR); end
    tick();
    total++; if (if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h003100B3 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL boot_edge2: got %h %h %b want 00000000 003100b3 1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    tick();
    total++; if (if_id_pc_o !== 32'h4 || if_id_instr_o !== 32'h00308233) begin bad++; $display("FAIL boot_edge3: got %h %h want 00000004 00308233", if_id_pc_o, if_id_instr_o); end
    tick();
    total++; if (if_id_pc_o !== 32'h8 || if_id_instr_o !== 32'h01E00203 || fetch_count_o !== 32'd3) begin bad++; $display("FAIL boot_edge4: got %h %h cnt=%0d want 00000008 01e00203 3", if_id_pc_o, if_id_instr_o, fetch_count_o); end
    total++; if (address_bus_IR !== 32'hC) begin bad++; $display("FAIL boot_pc4: got %h want 0000000c", address_bus_IR); end
  endtask

  task automatic test_stall;
    do_reset();
    tick(); tick(); tick();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (address_bus_IR !== 32'h8) begin bad++; $display("FAIL stall_pc_%0d: got %h want 00000008", i, address_bus_IR); end
      total++; if (if_id_pc_o !== 32'h4 || if_id_instr_o !== 32'h00308233 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL stall_hold_%0d: got %h %h %b want 00000004 00308233 1", i, if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    end
    stall_i = 1'b0;
    tick();
    total++; if (if_id_pc_o !== 32'h8 || if_id_instr_o !== 32'h01E00203 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL stall_release: got %h %h %b want 00000008 01e00203 1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    total++; if (fetch_count_o !== 32'd3) begin bad++; $display("FAIL stall_count: got %0d want 3", fetch_count_o); end
  endtask

  task automatic test_redirect_and_misalign;
    do_reset();
    tick(); tick(); tick();
    redirect_i        = 1'b1;
    redirect_target_i = 32'h14;
    stall_i           = 1'b1;
    tick();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    total++; if (address_bus_IR !== 32'h14) begin bad++; $display("FAIL redir_pc: got %h want 00000014", address_bus_IR); end
    total++; if (if_id_instr_o !== 32'h13 || if_id_valid_o !== 1'b0) begin bad++; $display("FAIL redir_flush: got %h %b want 00000013 0", if_id_instr_o, if_id_valid_o); end
    tick();
    total++; if (if_id_pc_o !== 32'h14 || if_id_instr_o !== 32'h0000027F || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL redir_target: got %h %h %b want 00000014 0000027f 1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    redirect_i        = 1'b1;
    redirect_target_i = 32'h16;
    tick();
    redirect_i = 1'b0;
    total++; if (misalign_o !== 1'b1 || halted_o !== 1'b1 || if_id_valid_o !== 1'b0) begin bad++; $display("FAIL misalign_flags: got mis=%b halt=%b valid=%b want 1 1 0", misalign_o, halted_o, if_id_valid_o); end
    total++; if (address_bus_IR !== 32'h18 || fetch_count_o !== 32'd3) begin bad++; $display("FAIL misalign_pc: got %h cnt=%0d want 00000018 3", address_bus_IR, fetch_count_o); end
    redirect_i        = 1'b1;
    redirect_target_i = 32'h0;
    tick();
    redirect_i = 1'b0;
    tick();
    total++; if (address_bus_IR !== 32'h18 || halted_o !== 1'b1 || if_id_valid_o !== 1'b0) begin bad++; $display("FAIL halted_ignore_redir: got pc=%h halt=%b valid=%b want 00000018 1 0", address_bus_IR, halted_o, if_id_valid_o); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (misalign_o !== 1'b0 || halted_o !== 1'b0) begin bad++; $display("FAIL misalign_reset: got mis=%b halt=%b want 0 0", misalign_o, halted_o); end
  endtask

  task automatic test_halt;
    do_reset();
    redirect_i        = 1'b1;
    redirect_target_i = 32'h20;
    tick();
    redirect_i = 1'b0;
    total++; if (address_bus_IR !== 32'h20 || if_id_valid_o !== 1'b0) begin bad++; $display("FAIL boot_redir: got pc=%h valid=%b want 00000020 0", address_bus_IR, if_id_valid_o); end
    tick();
    total++; if (if_id_pc_o !== 32'h20 || if_id_instr_o !== 32'h00100073 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL halt_capture: got %h %h %b want 00000020 00100073 1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    total++; if (halted_o !== 1'b1 || address_bus_IR !== 32'h20 || fetch_count_o !== 32'd1) begin bad++; $display("FAIL halt_enter: got halt=%b pc=%h cnt=%0d want 1 00000020 1", halted_o, address_bus_IR, fetch_count_o); end
    tick();
    total++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13 || if_id_pc_o !== 32'h20) begin bad++; $display("FAIL halt_flush: got %h %h %b want 00000020 00000013 0", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    stall_i = 1'b1;
    tick();
    stall_i = 1'b0;
    tick();
    total++; if (halted_o !== 1'b1 || misalign_o !== 1'b0 || address_bus_IR !== 32'h20 || fetch_count_o !== 32'd1) begin bad++; $display("FAIL halt_frozen: got halt=%b mis=%b pc=%h cnt=%0d want 1 0 00000020 1", halted_o, misalign_o, address_bus_IR, fetch_count_o); end
  endtask

  task automatic test_wrap;
    do_reset();
    redirect_i        = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    tick();
    total++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_instr_o !== 32'h0AB0_0093 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_capture: got %h %h %b want fffffffc 0ab00093 1", if_id_pc_o, if_id_instr_o, if_id_valid_o); end
    total++; if (address_bus_IR !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", address_bus_IR); end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    total++; if (address_bus_IR !== 32'h10 || fetch_count_o !== 32'd4) begin bad++; $display("FAIL pre_async: got pc=%h cnt=%0d want 00000010 4", address_bus_IR, fetch_count_o); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (address_bus_IR !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13 || fetch_count_o !== 32'h0) begin bad++; $display("FAIL async_reset: got pc=%h valid=%b instr=%h cnt=%0d want 00000000 0 00000013 0", address_bus_IR, if_id_valid_o, if_id_instr_o, fetch_count_o); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (if_id_valid_o !== 1'b0 || address_bus_IR !== 32'h0) begin bad++; $display("FAIL reboot_edge1: got valid=%b pc=%h want 0 00000000", if_id_valid_o, address_bus_IR); end
    tick();
    total++; if (if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h003100B3 || if_id_valid_o !== 1'b1 || fetch_count_o !== 32'd1) begin bad++; $display("FAIL reboot_edge2: got %h %h %b cnt=%0d want 00000000 003100b3 1 1", if_id_pc_o, if_id_instr_o, if_id_valid_o, fetch_count_o); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0]  = 32'h003100B3;
    mem[1]  = 32'h00308233;
    mem[2]  = 32'h01E00203;
    mem[5]  = 32'h0000027F;
    mem[8]  = 32'h00100073;
    mem[15] = 32'h0AB0_0093;

    test_reset();
    test_boot();
    test_stall();
    test_redirect_and_misalign();
    test_halt();
    test_wrap();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
